// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data access.
// Data wins unless fetch has been starved for STARVE_MAX data completions.
module memory_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int RETRY_MAX  = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;

    state_t         state, next_state, arb_state;
    logic [SW-1:0]  starve_cnt;
    logic [RW-1:0]  retry_cnt;
    logic           dreq, access, i_done, d_done, grant_done, abort;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == RAM_ACCESS);

    // A grant finishes on the ACCESS cycle; a reset in that cycle suppresses it.
    assign i_done     = (state == IGNT) && access && !RST;
    assign d_done     = (state == DGNT) && access && !RST;
    assign grant_done = i_done | d_done;
    assign abort      = !access && (((state == IGNT) && !iREN) || ((state == DGNT) && !dreq));

    always_comb begin
        arb_state = IDLE;
        if (dreq && (starve_cnt < STARVE_LIM))
            arb_state = DGNT;
        else if (iREN)
            arb_state = IGNT;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       next_state = arb_state;
            IGNT, DGNT: begin
                if (grant_done)  next_state = arb_state;
                else if (abort)  next_state = IDLE;
            end
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            DGNT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
        iwait = iREN & ~i_done;
        dwait = dreq & ~d_done;
        iload = i_done ? ramload : '0;
        dload = d_done ? ramload : '0;
    end

    // Any cycle without a pending fetch means fetch is not being starved.
    always_ff @(posedge CLK) begin
        if (RST || !iREN || i_done)
            starve_cnt <= '0;
        else if (d_done && (starve_cnt < STARVE_LIM))
            starve_cnt <= starve_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            retry_cnt <= '0;
            err       <= 1'b0;
        end else if ((state == IDLE) || grant_done || abort) begin
            retry_cnt <= '0;
        end else if (ramstate == RAM_ERROR) begin
            if (retry_cnt < RETRY_LIM)
                retry_cnt <= retry_cnt + 1'b1;
            if (retry_cnt >= RETRY_LIM - 1'b1)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch, contention, starvation, flush, error, reset.
module tb_memory_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, err;

    int n_cmp = 0;
    int n_bad = 0;

    memory_arbiter #(.STARVE_MAX(4), .RETRY_MAX(3)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Drive point: 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0; ramload = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        RST = 1; iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0;
        dstore = '0; ramload = '0; ramstate = 2'd0;
        tick();
        tick();
        RST = 0;
        #1;
        n_cmp++;
        if ({ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, err} !== {2'b00, 64'h0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, err});
        end
        n_cmp++;
        if (dut.starve_cnt !== 3'd0) begin
            n_bad++; $display("FAIL reset_starve got %0d want 0", dut.starve_cnt);
        end
    endtask

    task automatic test_lone_fetch();
        int lows = 0;
        tick();
        iREN = 1; iaddr = 32'h40; ramstate = 2'd0;
        #1;
        if (!iwait) lows++;
        n_cmp++;
        if (ramREN !== 1'b0) begin
            n_bad++; $display("FAIL fetch_idle_ren got %b want 0", ramREN);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            ramstate = (c == 2) ? 2'd2 : 2'd1;
            ramload  = (c == 2) ? 32'h2402000A : 32'hFFFF_FFFF;
            #1;
            if (!iwait) lows++;
            n_cmp++;
            if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
                n_bad++; $display("FAIL fetch_ram c%0d got %h want %h", c, {ramREN, ramWEN, ramaddr}, {2'b10, 32'h40});
            end
        end
        n_cmp++;
        if (iload !== 32'h2402000A) begin
            n_bad++; $display("FAIL fetch_load got %h want 2402000a", iload);
        end
        n_cmp++;
        if (lows !== 1) begin
            n_bad++; $display("FAIL fetch_wait_low got %0d cycles want 1", lows);
        end
        settle();
        n_cmp++;
        if ({ramREN, ramaddr} !== 33'h0) begin
            n_bad++; $display("FAIL fetch_back_idle got %h want 0", {ramREN, ramaddr});
        end
    endtask

    task automatic test_contention();
        tick();
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h100; ramstate = 2'd0;
        tick();
        ramstate = 2'd1;
        #1;
        n_cmp++;
        if ({ramREN, ramWEN, ramaddr, iwait, dwait} !== {2'b10, 32'h100, 2'b11}) begin
            n_bad++; $display("FAIL cont_dgnt got %h want %h", {ramREN, ramWEN, ramaddr, iwait, dwait}, {2'b10, 32'h100, 2'b11});
        end
        tick();
        ramstate = 2'd2; ramload = 32'hCAFE0001; dREN = 0;
        #1;
        n_cmp++;
        if ({dload, iwait, iload} !== {32'hCAFE0001, 1'b1, 32'h0}) begin
            n_bad++; $display("FAIL cont_dcomplete got %h want %h", {dload, iwait, iload}, {32'hCAFE0001, 1'b1, 32'h0});
        end
        tick();
        ramload = 32'h11112222;
        #1;
        n_cmp++;
        if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h200, 1'b0, 32'h11112222}) begin
            n_bad++; $display("FAIL cont_ignt_next got %h want %h", {ramREN, ramaddr, iwait, iload}, {1'b1, 32'h200, 1'b0, 32'h11112222});
        end
        settle();
    endtask

    task automatic test_starvation();
        tick();
        iREN = 1; iaddr = 32'h300; dWEN = 1; daddr = 32'h500; ramstate = 2'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            ramstate = 2'd2; dstore = 32'h70 + k;
            #1;
            n_cmp++;
            if ({ramREN, ramWEN, ramaddr, ramstore, dwait, dut.starve_cnt} !==
                {2'b01, 32'h500, 32'h70 + k, 1'b0, 3'((k > 4) ? 4 : k)}) begin
                n_bad++;
                $display("FAIL starve_write%0d got %h want %h", k, {ramREN, ramWEN, ramaddr, ramstore, dwait, dut.starve_cnt},
                         {2'b01, 32'h500, 32'h70 + k, 1'b0, 3'((k > 4) ? 4 : k)});
            end
        end
        tick();
        ramload = 32'h0BAD_F00D;
        #1;
        n_cmp++;
        if ({ramREN, ramWEN, ramaddr, dwait, iload, dut.starve_cnt} !== {2'b10, 32'h300, 1'b1, 32'h0BADF00D, 3'd4}) begin
            n_bad++;
            $display("FAIL starve_fetch_wins got %h want %h", {ramREN, ramWEN, ramaddr, dwait, iload, dut.starve_cnt},
                     {2'b10, 32'h300, 1'b1, 32'h0BADF00D, 3'd4});
        end
        tick();
        ramstate = 2'd1;
        #1;
        n_cmp++;
        if (dut.starve_cnt !== 3'd0) begin
            n_bad++; $display("FAIL starve_cleared got %0d want 0", dut.starve_cnt);
        end
        settle();
    endtask

    task automatic test_flush_abort();
        tick();
        dREN = 1; daddr = 32'h600; ramstate = 2'd0;
        tick();
        ramstate = 2'd1;
        #1;
        n_cmp++;
        if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h600, 1'b1}) begin
            n_bad++; $display("FAIL flush_grant got %h want %h", {ramREN, ramaddr, dwait}, {1'b1, 32'h600, 1'b1});
        end
        tick();
        dREN = 0;
        #1;
        n_cmp++;
        if (dload !== 32'h0) begin
            n_bad++; $display("FAIL flush_no_load got %h want 0", dload);
        end
        tick();
        ramstate = 2'd2; ramload = 32'h5A5A5A5A;
        #1;
        n_cmp++;
        if ({ramREN, ramWEN, ramaddr, dload} !== {2'b00, 64'h0}) begin
            n_bad++; $display("FAIL flush_idle got %h want 0", {ramREN, ramWEN, ramaddr, dload});
        end
        settle();
    endtask

    task automatic test_error();
        tick();
        iREN = 1; iaddr = 32'h44; ramstate = 2'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            ramstate = 2'd3;
            #1;
            n_cmp++;
            if ({err, iwait} !== 2'b01) begin
                n_bad++; $display("FAIL err_wait c%0d got %b want 01", c, {err, iwait});
            end
        end
        tick();
        ramstate = 2'd2; ramload = 32'h0000ABCD;
        #1;
        n_cmp++;
        if ({err, iwait, iload} !== {2'b10, 32'h0000ABCD}) begin
            n_bad++; $display("FAIL err_complete got %h want %h", {err, iwait, iload}, {2'b10, 32'h0000ABCD});
        end
        settle();
        n_cmp++;
        if ({err, dut.retry_cnt} !== 3'b100) begin
            n_bad++; $display("FAIL err_sticky got %b want 100", {err, dut.retry_cnt});
        end
    endtask

    task automatic test_reset_mid_grant();
        tick();
        dWEN = 1; daddr = 32'h700; dstore = 32'h55; ramstate = 2'd0;
        tick();
        ramstate = 2'd1;
        #1;
        n_cmp++;
        if ({ramWEN, ramaddr, ramstore} !== {1'b1, 32'h700, 32'h55}) begin
            n_bad++; $display("FAIL rst_pre got %h want %h", {ramWEN, ramaddr, ramstore}, {1'b1, 32'h700, 32'h55});
        end
        tick();
        RST = 1; ramstate = 2'd2;
        #1;
        n_cmp++;
        if (dwait !== 1'b1) begin
            n_bad++; $display("FAIL rst_no_complete got %b want 1", dwait);
        end
        tick();
        RST = 0; dWEN = 0; ramstate = 2'd0;
        #1;
        n_cmp++;
        if ({ramREN, ramWEN, ramaddr, err} !== {2'b00, 32'h0, 1'b0}) begin
            n_bad++; $display("FAIL rst_after got %h want 0", {ramREN, ramWEN, ramaddr, err});
        end
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_contention();
        test_starvation();
        test_flush_abort();
        test_error();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
